clk_div_calc: RTL and testbench

Upstream companion of the runtime clock divider. Converts a requested output frequency in Hz into the integer division factor `div = round(CLK_FREQ_HZ / freq_hz)`. It presents that factor on `div` / `div_valid`, which connect directly to the divider's `div` / `div_valid` inputs. The quotient is computed by a multi-cycle restoring division FSM, so no DSP or combinational divider is inferred.

---
 rtl/clk_div_calc_if.sv | 20 ++
 rtl/clk_div_calc.sv | 101 ++++++++++
 tb/tb_clk_div_calc.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_calc_if.sv
// rtl/clk_div_calc_if.sv - request/result bundle between upstream and clk_div_calc
interface clk_div_calc_if;
  logic [31:0] freq_hz;
  logic        freq_valid;
  logic        freq_ready;
  logic [31:0] div;
  logic        div_valid;
  logic        err;
  logic        busy;

  modport master (
    output freq_hz, freq_valid,
    input  freq_ready, div, div_valid, err, busy
  );

  modport slave (
    input  freq_hz, freq_valid,
    output freq_ready, div, div_valid, err, busy
  );
endinterface

// File: rtl/clk_div_calc.sv
// rtl/clk_div_calc.sv - frequency-to-division-factor converter, round(CLK_FREQ_HZ / freq_hz)
module clk_div_calc #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic          clk,
  input  logic          rstn,
  clk_div_calc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, CALC, DONE} state_t;

  localparam logic [32:0] CLK33 = {1'b0, CLK_FREQ_HZ};

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] q;
  logic [32:0] n_r;
  logic [31:0] freq_r;

  logic [31:0] div_r;
  logic        div_valid_r;
  logic        err_r;
  logic        ready_r;

  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_sub;

  // rem stays below freq after every step, so the shifted value fits 33 bits
  // and the difference always fits back into 32.
  always_comb begin
    rem_sh  = {rem, n_r[cnt]};
    ge      = (rem_sh >= {1'b0, freq_r});
    rem_sub = rem_sh[31:0] - freq_r;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      ready_r     <= 1'b1;
      div_valid_r <= 1'b0;
      err_r       <= 1'b0;
      div_r       <= 32'd1;
      cnt         <= 6'd0;
      rem         <= 32'd0;
      q           <= 32'd0;
      n_r         <= 33'd0;
      freq_r      <= 32'd0;
    end else begin
      div_valid_r <= 1'b0;
      err_r       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.freq_valid && ready_r) begin
            freq_r  <= bus.freq_hz;
            ready_r <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (freq_r == 32'd0 || freq_r > CLK_FREQ_HZ) begin
            err_r   <= 1'b1;
            ready_r <= 1'b1;
            state   <= IDLE;
          end else begin
            n_r   <= CLK33 + {2'b00, freq_r[31:1]};
            rem   <= 32'd0;
            q     <= 32'd0;
            cnt   <= 6'd32;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= ge ? rem_sub : rem_sh[31:0];
          // Quotient bit 32 is always 0 and is shifted out on the last step.
          q   <= {q[30:0], ge};
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            state <= DONE;
          end
        end
        DONE: begin
          div_r       <= q;
          div_valid_r <= 1'b1;
          ready_r     <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.freq_ready = ready_r;
  assign bus.busy       = ~ready_r;
  assign bus.div        = div_r;
  assign bus.div_valid  = div_valid_r;
  assign bus.err        = err_r;
endmodule

// File: tb/tb_clk_div_calc.sv
// tb/tb_clk_div_calc.sv - directed and randomised checks of clk_div_calc against an arithmetic model
module tb_clk_div_calc;
  localparam int unsigned CLK_HZ = 100_000_000;

  logic clk;
  logic rstn;
  clk_div_calc_if bus ();

  clk_div_calc #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_div;

  function automatic logic [31:0] model_div(input logic [31:0] f);
    longint unsigned c, fl;
    c  = CLK_HZ;
    fl = f;
    return 32'((c + fl / 2) / fl);
  endfunction

  function automatic bit model_err(input logic [31:0] f);
    return (f == 32'd0) || (f > CLK_HZ);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.freq_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.freq_ready) check("idle_timeout", 0, 1);
  endtask

  // Called at a negedge k cycles after the accept edge; returns the k of the pulse or -1.
  task automatic wait_pulse(input int k0, output int k, output bit dv, output bit er, output bit rdy_low);
    k = k0; dv = 0; er = 0; rdy_low = 1;
    while (k < 80) begin
      if (bus.div_valid || bus.err) begin
        dv = bus.div_valid;
        er = bus.err;
        return;
      end
      if (bus.freq_ready) rdy_low = 0;
      @(negedge clk);
      k++;
    end
    k = -1;
  endtask

  task automatic post_pulse_checks(input string tag, input int k, input bit dv, input bit er,
                                   input bit rdy_low, input bit e_err);
    check({tag, "_latency"}, 64'(k), e_err ? 64'd1 : 64'd35);
    check({tag, "_kind"}, {dv, er}, e_err ? 2'b01 : 2'b10);
    check({tag, "_busy_ready_low"}, rdy_low, 1);
    check({tag, "_ready_at_pulse"}, {bus.freq_ready, bus.busy}, 2'b10);
    check({tag, "_div"}, bus.div, exp_div);
    @(negedge clk);
    check({tag, "_pulse_width"}, {bus.div_valid, bus.err}, 2'b00);
  endtask

  task automatic do_req(input string tag, input logic [31:0] f);
    int k;
    bit dv, er, rl, e_err;
    wait_idle();
    e_err = model_err(f);
    bus.freq_hz    = f;
    bus.freq_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.freq_valid = 1'b0;
    bus.freq_hz    = $urandom;
    if (!e_err) exp_div = model_div(f);
    wait_pulse(0, k, dv, er, rl);
    post_pulse_checks(tag, k, dv, er, rl, e_err);
  endtask

  initial begin
    int k;
    bit dv, er, rl, seen;
    logic [31:0] f;

    rstn           = 1'b0;
    bus.freq_hz    = 32'd0;
    bus.freq_valid = 1'b0;
    exp_div        = 32'd1;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.freq_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_div", bus.div, 1);
    check("rst_pulses", {bus.div_valid, bus.err}, 2'b00);
    rstn = 1'b1;
    @(negedge clk);

    do_req("f25M", 32'd25_000_000);
    check("f25M_abs", bus.div, 4);
    do_req("f30M", 32'd30_000_000);
    do_req("f40M", 32'd40_000_000);
    do_req("f100M", 32'd100_000_000);
    do_req("f1", 32'd1);
    do_req("f25M_again", 32'd25_000_000);
    do_req("rej0", 32'd0);
    check("rej0_keep", bus.div, 4);
    do_req("rej150M", 32'd150_000_000);
    do_req("rej_max", 32'hFFFF_FFFF);
    do_req("f_clk_plus1", CLK_HZ + 1);

    // Back-to-back with freq_valid held and freq_hz changed mid-busy.
    wait_idle();
    bus.freq_hz    = 32'd10_000_000;
    bus.freq_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (20) @(negedge clk);
    bus.freq_hz = 32'd20_000_000;
    exp_div = 32'd10;
    wait_pulse(20, k, dv, er, rl);
    check("b2b1_latency", 64'(k), 35);
    check("b2b1_kind", {dv, er}, 2'b10);
    check("b2b1_div", bus.div, 10);
    check("b2b1_ready", bus.freq_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.freq_valid = 1'b0;
    check("b2b2_accepted", bus.freq_ready, 0);
    exp_div = 32'd5;
    wait_pulse(0, k, dv, er, rl);
    post_pulse_checks("b2b2", k, dv, er, rl, 1'b0);

    // Reset in the middle of CALC.
    wait_idle();
    bus.freq_hz    = 32'd7_000_000;
    bus.freq_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.freq_valid = 1'b0;
    repeat (15) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_div = 32'd1;
    check("mrst_ready", bus.freq_ready, 1);
    check("mrst_busy", bus.busy, 0);
    check("mrst_div", bus.div, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.div_valid || bus.err) seen = 1;
      @(negedge clk);
    end
    check("mrst_no_pulse", seen, 0);
    do_req("mrst_fresh", 32'd7_000_000);
    check("mrst_fresh_abs", bus.div, 14);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(19, 0))
        0:       f = 32'd1;
        1:       f = CLK_HZ;
        2:       f = $urandom_range(1000, 1);
        default: f = $urandom_range(CLK_HZ, 1);
      endcase
      repeat ($urandom_range(3, 0)) @(negedge clk);
      do_req("rand", f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
